// File: rtl/ml605_rst_seq.sv
// MMCM reset/startup sequencer: pulses the MMCM reset, qualifies lock, then
// releases the overclocked test logic after a hold time; retries on lock loss, timeout or button press.
module ml605_rst_seq #(
    parameter int unsigned MMCM_RST_CYCLES = 64,
    parameter int unsigned LOCK_STABLE     = 2000,
    parameter int unsigned LOCK_TIMEOUT    = 200000,
    parameter int unsigned HOLD_CYCLES     = 256,
    parameter int unsigned DEBOUNCE        = 1000000
) (
    input  logic       clk_200,
    input  logic       rst,
    input  logic       mmcm_locked,
    input  logic       btn_rst,
    output logic       mmcm_rst,
    output logic       user_rst,
    output logic       ready,
    output logic [7:0] lock_loss_cnt,
    output logic [3:0] retry_cnt
);

    localparam int unsigned RW = $clog2(MMCM_RST_CYCLES + 1);
    localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned DW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {MMCM_RST, WAIT_LOCK, HOLD, RUN} state_t;

    state_t          state_q, state_d;
    logic            lock_meta_q, locked_s;
    logic            btn_meta_q, btn_s_q;
    logic [DW-1:0]   db_q, db_d;
    logic            press;
    logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [SW-1:0]   stab_q, stab_d;
    logic [TW-1:0]   to_q, to_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [7:0]      loss_q, loss_d;
    logic [3:0]      retry_q, retry_d;
    logic            mmcm_rst_q, user_rst_q, ready_q;

    // Synchronizers carry no reset so they keep tracking the pins during rst.
    always_ff @(posedge clk_200) begin
        lock_meta_q <= mmcm_locked;
        locked_s    <= lock_meta_q;
        btn_meta_q  <= btn_rst;
        btn_s_q     <= btn_meta_q;
    end

    // Debounce counter saturates at DEBOUNCE, so press fires once per hold.
    always_comb begin
        db_d = db_q;
        if (!btn_s_q)
            db_d = '0;
        else if (db_q != DW'(DEBOUNCE))
            db_d = db_q + 1'b1;
    end

    assign press = btn_s_q && (db_q == DW'(DEBOUNCE - 1));

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = '0;
        stab_d    = '0;
        to_d      = '0;
        hold_d    = '0;
        loss_d    = loss_q;
        retry_d   = retry_q;
        if (press) begin
            state_d = MMCM_RST;
        end else begin
            case (state_q)
                MMCM_RST: begin
                    if (rst_cnt_q == RW'(MMCM_RST_CYCLES - 1))
                        state_d = WAIT_LOCK;
                    else
                        rst_cnt_d = rst_cnt_q + 1'b1;
                end
                WAIT_LOCK: begin
                    if (locked_s && (stab_q == SW'(LOCK_STABLE - 1))) begin
                        state_d = HOLD;
                    end else if (to_q == TW'(LOCK_TIMEOUT - 1)) begin
                        state_d = MMCM_RST;
                        if (retry_q != '1)
                            retry_d = retry_q + 1'b1;
                    end else begin
                        stab_d = locked_s ? stab_q + 1'b1 : '0;
                        to_d   = to_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (!locked_s) begin
                        state_d = MMCM_RST;
                        if (loss_q != '1)
                            loss_d = loss_q + 1'b1;
                    end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                        state_d = RUN;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_d = MMCM_RST;
                        if (loss_q != '1)
                            loss_d = loss_q + 1'b1;
                    end
                end
                default: state_d = MMCM_RST;
            endcase
        end
    end

    always_ff @(posedge clk_200) begin
        if (rst) begin
            state_q    <= MMCM_RST;
            rst_cnt_q  <= '0;
            stab_q     <= '0;
            to_q       <= '0;
            hold_q     <= '0;
            db_q       <= '0;
            loss_q     <= '0;
            retry_q    <= '0;
            mmcm_rst_q <= 1'b1;
            user_rst_q <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            stab_q     <= stab_d;
            to_q       <= to_d;
            hold_q     <= hold_d;
            db_q       <= db_d;
            loss_q     <= loss_d;
            retry_q    <= retry_d;
            mmcm_rst_q <= (state_d == MMCM_RST);
            user_rst_q <= (state_d != RUN);
            ready_q    <= (state_d == RUN);
        end
    end

    assign mmcm_rst      = mmcm_rst_q;
    assign user_rst      = user_rst_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = loss_q;
    assign retry_cnt     = retry_q;

endmodule

// File: tb/tb_ml605_rst_seq.sv
// Bench for ml605_rst_seq: directed vector table, hand-built multi-cycle corner
// cases, then random stimulus against an elapsed-time reference model.
module tb_ml605_rst_seq;

    localparam int M = 4;
    localparam int S = 8;
    localparam int T = 32;
    localparam int H = 16;
    localparam int D = 5;

    logic       clk_200 = 1'b0;
    logic       rst_i = 1'b1;
    logic       lk_i = 1'b1;
    logic       btn_i = 1'b0;
    logic       mmcm_rst, user_rst, ready;
    logic [7:0] lock_loss_cnt;
    logic [3:0] retry_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    ml605_rst_seq #(
        .MMCM_RST_CYCLES(M),
        .LOCK_STABLE(S),
        .LOCK_TIMEOUT(T),
        .HOLD_CYCLES(H),
        .DEBOUNCE(D)
    ) dut (
        .clk_200(clk_200),
        .rst(rst_i),
        .mmcm_locked(lk_i),
        .btn_rst(btn_i),
        .mmcm_rst(mmcm_rst),
        .user_rst(user_rst),
        .ready(ready),
        .lock_loss_cnt(lock_loss_cnt),
        .retry_cnt(retry_cnt)
    );

    always #5 clk_200 = ~clk_200;

    // Reference model: phase 0=mmcm reset, 1=wait lock, 2=hold, 3=run, timed by
    // elapsed edges since phase entry and run lengths of the delayed inputs.
    int   cyc = 0;
    int   ph = 0, entry = 0, lrun = 0, brun = 0, m_loss = 0, m_retry = 0;
    logic lk_h [0:8191];
    logic bt_h [0:8191];

    function automatic logic [14:0] pk(input logic a, input logic b, input logic c,
                                       input logic [7:0] l, input logic [3:0] r);
        return {a, b, c, l, r};
    endfunction

    task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h (mmcm,user,ready,loss,retry) expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic r);
        logic ls, bs, enter;
        int   el, nxt;
        cyc++;
        lk_h[cyc] = lk_i;
        bt_h[cyc] = btn_i;
        ls = (cyc >= 2) ? lk_h[cyc-2] : 1'b0;
        bs = (cyc >= 2) ? bt_h[cyc-2] : 1'b0;
        if (r) begin
            ph = 0; entry = cyc; lrun = 0; brun = 0; m_loss = 0; m_retry = 0;
        end else begin
            brun  = bs ? brun + 1 : 0;
            el    = cyc - entry;
            nxt   = ph;
            enter = 1'b0;
            if (brun == D) begin
                nxt = 0; enter = 1'b1;
            end else begin
                case (ph)
                    0: if (el == M) begin nxt = 1; enter = 1'b1; end
                    1: begin
                        lrun = ls ? lrun + 1 : 0;
                        if (lrun == S) begin
                            nxt = 2; enter = 1'b1;
                        end else if (el == T) begin
                            if (m_retry < 15) m_retry++;
                            nxt = 0; enter = 1'b1;
                        end
                    end
                    2: if (!ls) begin
                        if (m_loss < 255) m_loss++;
                        nxt = 0; enter = 1'b1;
                    end else if (el == H) begin
                        nxt = 3; enter = 1'b1;
                    end
                    default: if (!ls) begin
                        if (m_loss < 255) m_loss++;
                        nxt = 0; enter = 1'b1;
                    end
                endcase
            end
            if (enter) begin
                ph = nxt; entry = cyc; lrun = 0;
            end
        end
    endtask

    task automatic tick(input logic r, input logic lk, input logic b);
        @(negedge clk_200);
        rst_i = r;
        lk_i  = lk;
        btn_i = b;
        @(posedge clk_200);
        model_step(r);
        #1;
        chk($sformatf("model cyc %0d", cyc),
            pk(mmcm_rst, user_rst, ready, lock_loss_cnt, retry_cnt),
            pk(ph == 0, ph != 3, ph == 3, 8'(m_loss), 4'(m_retry)));
    endtask

    task automatic chk_out(input string name, input logic em, input logic eu, input logic er,
                           input int eloss, input int eretry);
        chk(name, pk(mmcm_rst, user_rst, ready, lock_loss_cnt, retry_cnt),
            pk(em, eu, er, 8'(eloss), 4'(eretry)));
    endtask

    typedef struct {
        logic r, lk, b;
        int   n;
        logic em, eu, er;
        int   eloss, eretry;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // startup with lock tied high: ready at edge M+S+H = 28
        tbl.push_back('{1'b1, 1'b1, 1'b0, 5,  1'b1, 1'b1, 1'b0, 0, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 3,  1'b1, 1'b1, 1'b0, 0, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 0, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 23, 1'b0, 1'b1, 1'b0, 0, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 0, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b1, 0, 0});
        // one-cycle lock drop in RUN, seen two edges later
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 0, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 0, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 27, 1'b0, 1'b1, 1'b0, 1, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 5,  1'b0, 1'b0, 1'b1, 1, 0});
        // button: 4 cycles ignored; 5+ gives exactly one restart
        tbl.push_back('{1'b0, 1'b1, 1'b1, 4,  1'b0, 1'b0, 1'b1, 1, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 6,  1'b0, 1'b0, 1'b1, 1, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 6,  1'b0, 1'b0, 1'b1, 1, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b0, 1, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 27, 1'b0, 1'b1, 1'b0, 1, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1,  1'b0, 1'b0, 1'b1, 1, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 20, 1'b0, 1'b0, 1'b1, 1, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 5,  1'b0, 1'b0, 1'b1, 1, 0});
        // rst in RUN
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1'b0, 0, 0});

        foreach (tbl[i]) begin
            for (int j = 0; j < tbl[i].n; j++)
                tick(tbl[i].r, tbl[i].lk, tbl[i].b);
            chk_out($sformatf("vec %0d", i), tbl[i].em, tbl[i].eu, tbl[i].er,
                    tbl[i].eloss, tbl[i].eretry);
        end

        // lock never arrives: 4 + 32 cycles per attempt, retry saturates at 15
        for (int k = 1; k <= 16; k++) begin
            for (int j = 0; j < 35; j++) tick(1'b0, 1'b0, 1'b0);
            chk_out($sformatf("retry wait %0d", k), 1'b0, 1'b1, 1'b0, 0, (k - 1 > 15) ? 15 : k - 1);
            tick(1'b0, 1'b0, 1'b0);
            chk_out($sformatf("retry pulse %0d", k), 1'b1, 1'b1, 1'b0, 0, (k > 15) ? 15 : k);
        end

        // glitched lock: 7 high, 1 low, then steady; ready must come 38 edges after MMCM entry
        for (int j = 0; j < 4; j++) tick(1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 7; j++) tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 25; j++) tick(1'b0, 1'b1, 1'b0);
        chk_out("glitch not ready", 1'b0, 1'b1, 1'b0, 0, 15);
        tick(1'b0, 1'b1, 1'b0);
        chk_out("glitch ready", 1'b0, 1'b0, 1'b1, 0, 15);

        // lose lock, reach HOLD with nonzero counters, then rst
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk_out("loss before hold", 1'b1, 1'b1, 1'b0, 1, 15);
        for (int j = 0; j < 13; j++) tick(1'b0, 1'b1, 1'b0);
        chk_out("in hold", 1'b0, 1'b1, 1'b0, 1, 15);
        tick(1'b1, 1'b1, 1'b0);
        chk_out("rst in hold", 1'b1, 1'b1, 1'b0, 0, 0);

        // random segments of lock, button and occasional rst
        while (cyc < 7000) begin
            logic lk_v, b_v;
            int   len;
            lk_v = ($urandom_range(0, 3) != 0);
            b_v  = ($urandom_range(0, 4) == 0);
            len  = $urandom_range(1, 40);
            for (int j = 0; j < len; j++)
                tick(($urandom_range(0, 299) == 0), lk_v, b_v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ml605_rst_seq.md
Name: ml605_rst_seq

Overview:
- Reset/startup sequencer clocked by the board's 200 MHz reference clock, `clk_200`.
- Drives the reset of the MMCM that generates the overclocked test clock.
- Waits for the MMCM's `locked` signal to be stable, then holds the downstream test logic in reset for a programmable time before releasing it.
- Re-runs the sequence on lock loss, lock timeout or a debounced push-button press, and keeps counts of lock losses and retries for the test platform.

Parameters:
- MMCM_RST_CYCLES, 64: cycles `mmcm_rst` is held high per attempt (≥1).
- LOCK_STABLE, 2000: consecutive cycles of synchronized `locked` required to accept lock (≥1).
- LOCK_TIMEOUT, 200000: cycles in WAIT_LOCK before an attempt is abandoned; must exceed LOCK_STABLE.
- HOLD_CYCLES, 256: cycles `user_rst` stays high after lock is accepted (≥1).
- DEBOUNCE, 1000000: consecutive cycles `btn_rst` must be high to count as a press (≥1).

Ports:
- clk_200, input, 1: 200 MHz reference clock, the only clock.
- rst, input, 1: synchronous, active-high reset.
- mmcm_locked, input, 1: MMCM lock flag, asynchronous; passed through a 2-FF synchronizer internally (`locked_s`).
- btn_rst, input, 1: raw push-button, asynchronous; 2-FF synchronized, then debounced.
- mmcm_rst, output, 1: reset to the MMCM.
- user_rst, output, 1: reset to the overclocked test logic.
- ready, output, 1: high when the sequence is complete (RUN state).
- lock_loss_cnt, output, 8: saturating count of lock drops seen in HOLD or RUN.
- retry_cnt, output, 4: saturating count of lock timeouts.

Behaviour:
- All outputs are registered and are functions of the current state.
- Reset values, while `rst` is high:
  - state = MMCM_RST; all internal counters = 0.
  - mmcm_rst = 1, user_rst = 1, ready = 0.
  - lock_loss_cnt = 0, retry_cnt = 0.
- Synchronizer latency: `locked_s` follows `mmcm_locked` 2 cycles later; the synchronized button follows `btn_rst` 2 cycles later.
- Debounce:
  - A counter increments while the synchronized button is 1 and clears on any 0.
  - `press` pulses for exactly 1 cycle when the counter reaches DEBOUNCE.
  - No further `press` until the button has returned to 0.
- States and outputs:
  - MMCM_RST: mmcm_rst = 1, user_rst = 1, ready = 0. Stays exactly MMCM_RST_CYCLES cycles, then goes to WAIT_LOCK.
  - WAIT_LOCK: mmcm_rst = 0, user_rst = 1. A stable counter increments while `locked_s` = 1 and clears on any 0. A timeout counter increments every cycle.
    - Stable counter reaches LOCK_STABLE: go to HOLD.
    - Otherwise timeout counter reaches LOCK_TIMEOUT: retry_cnt++ (saturating at 15), go to MMCM_RST.
    - If both happen in the same cycle, lock wins and the state goes to HOLD.
  - HOLD: user_rst = 1. Stays exactly HOLD_CYCLES cycles, then goes to RUN. If `locked_s` = 0: lock_loss_cnt++ and go to MMCM_RST.
  - RUN: user_rst = 0, ready = 1. If `locked_s` = 0: lock_loss_cnt++ (saturating at 255) and go to MMCM_RST.
- Priority, highest first: rst > press > lock loss / timeout > normal progression.
  - `press` in any state goes to MMCM_RST.
  - `press` does not increment either counter.
- Every state entry clears the per-state counters, so each attempt restarts its full timing.
- Timing from the first edge with rst = 0, with `locked_s` continuously 1: ready rises after exactly MMCM_RST_CYCLES + LOCK_STABLE + HOLD_CYCLES edges.
- user_rst and ready change together on the same edge:
  - user_rst falls on the same edge that ready rises.
  - They rise/fall together again on any exit from RUN.
- Reset mid-operation: rst high in any state forces the reset values on the next edge.
- Counter widths: each counter is $clog2(parameter + 1) bits, with no wrap-around in any state.

Test Plan (overrides: MMCM_RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, HOLD_CYCLES=16, DEBOUNCE=5):
- mmcm_locked tied 1, rst released:
  - mmcm_rst high for 4 cycles.
  - user_rst falls and ready rises together 28 cycles after release.
  - Both counters stay 0.
- mmcm_locked held 0:
  - Expect a repeating 4-cycle mmcm_rst pulse, then 32 cycles in WAIT_LOCK, per attempt.
  - retry_cnt increments per attempt and saturates at 15 after 15 attempts.
  - ready stays 0 throughout.
- In RUN, drop mmcm_locked for 1 cycle:
  - 2 cycles later ready = 0, user_rst = 1, mmcm_rst = 1.
  - lock_loss_cnt = 1; ready returns after a full 28-cycle sequence.
- In WAIT_LOCK, toggle locked 1 for 7 cycles, 0 for 1 cycle, then steady 1:
  - HOLD is entered only after 8 consecutive high cycles.
  - The glitch does not count toward lock.
- btn_rst in RUN:
  - High for 4 cycles: no effect.
  - High for 5+ cycles: one press; sequence restarts, counters unchanged.
  - Holding btn_rst high longer produces no second restart.
- rst asserted in HOLD and in RUN: next edge gives exactly the reset values listed in Behaviour, and both counters are 0.
